// File: rtl/dtm_dmi_ctrl.sv
// DMI transaction sequencer for a RISC-V JTAG DTM.
// Takes the op/addr/data word scanned into the DMI register and runs one
// valid/ready request towards the Debug Module. It then collects the response.
// It also provides the capture word for the next DMI scan.
// The sticky dmistat error follows dmireset/dmihardreset semantics.
module dtm_dmi_ctrl #(
    parameter int ABITS = 7
) (
    input  logic               tclk,
    input  logic               trst,
    input  logic               upd_valid,
    input  logic [1:0]         upd_op,
    input  logic [ABITS-1:0]   upd_addr,
    input  logic [31:0]        upd_data,
    input  logic               capture,
    output logic [ABITS+33:0]  cap_dmi,
    input  logic               dmireset,
    input  logic               dmihardreset,
    output logic [1:0]         dmistat,
    output logic               busy,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [1:0]         req_op,
    output logic [ABITS-1:0]   req_addr,
    output logic [31:0]        req_data,
    input  logic               rsp_valid,
    output logic               rsp_ready,
    input  logic [1:0]         rsp_op,
    input  logic [31:0]        rsp_data
);

    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] STAT_OK    = 2'd0;
    localparam logic [1:0] STAT_FAIL  = 2'd2;
    localparam logic [1:0] STAT_BUSY  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [ABITS-1:0]   addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [ABITS-1:0]   last_addr_q, last_addr_d;
    logic [31:0]        result_q, result_d;
    logic [1:0]         dmistat_q, dmistat_d;

    logic               busy_evt_s;
    logic               rsp_err_s;
    logic               rsp_fire_s;
    logic [1:0]         stat_base_s;
    logic [1:0]         cap_op_s;

    // Error classification and sticky status computation.
    always_comb begin
        rsp_fire_s  = 1'b0;
        rsp_err_s   = 1'b0;
        busy_evt_s  = 1'b0;
        stat_base_s = dmistat_q;
        dmistat_d   = dmistat_q;

        if (state_q == ST_WAIT) begin
            rsp_fire_s = rsp_valid;
        end else begin
            rsp_fire_s = 1'b0;
        end

        if (rsp_fire_s && ((rsp_op == STAT_FAIL) || (rsp_op == STAT_BUSY))) begin
            rsp_err_s = 1'b1;
        end else begin
            rsp_err_s = 1'b0;
        end

        // An update or capture that lands while a transaction is outstanding is
        // a busy error. The outstanding transaction itself is not affected.
        if ((state_q != ST_IDLE) && (upd_valid || capture)) begin
            busy_evt_s = 1'b1;
        end else begin
            busy_evt_s = 1'b0;
        end

        // dmireset clears first. A set event in the same cycle then lands on
        // the cleared value, so an error is never lost.
        if (dmireset) begin
            stat_base_s = STAT_OK;
        end else begin
            stat_base_s = dmistat_q;
        end

        if (dmihardreset) begin
            dmistat_d = STAT_OK;
        end else if (stat_base_s != STAT_OK) begin
            dmistat_d = stat_base_s;
        end else if (busy_evt_s) begin
            dmistat_d = STAT_BUSY;
        end else if (rsp_err_s) begin
            dmistat_d = rsp_op;
        end else begin
            dmistat_d = STAT_OK;
        end
    end

    // Transaction FSM: next state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_addr_d = last_addr_q;
        result_d    = result_q;

        if (dmihardreset) begin
            // Abort the transaction. The last capture data survives the abort.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (upd_valid && (dmistat_q == STAT_OK) &&
                        ((upd_op == OP_READ) || (upd_op == OP_WRITE))) begin
                        state_d     = ST_REQ;
                        op_d        = upd_op;
                        addr_d      = upd_addr;
                        data_d      = upd_data;
                        last_addr_d = upd_addr;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        state_d = ST_IDLE;
                        if (op_q == OP_READ) begin
                            result_d = rsp_data;
                        end else begin
                            result_d = result_q;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge tclk or negedge trst) begin
        if (!trst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            addr_q      <= {ABITS{1'b0}};
            data_q      <= 32'd0;
            last_addr_q <= {ABITS{1'b0}};
            result_q    <= 32'd0;
            dmistat_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            result_q    <= result_d;
            dmistat_q   <= dmistat_d;
        end
    end

    // Output decode. All outputs come straight from registers.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        req_valid = (state_q == ST_REQ);
        rsp_ready = (state_q == ST_WAIT);
        req_op    = op_q;
        req_addr  = addr_q;
        req_data  = data_q;
        dmistat   = dmistat_q;
        if (state_q != ST_IDLE) begin
            cap_op_s = STAT_BUSY;
        end else begin
            cap_op_s = dmistat_q;
        end
        cap_dmi   = {last_addr_q, result_q, cap_op_s};
    end

endmodule

// File: tb/tb_dtm_dmi_ctrl.sv
// Self-checking bench for dtm_dmi_ctrl.
// The directed steps follow the DMI use cases, followed by randomized traffic.
// Every cycle is compared against a transaction-level reference model.
module tb_dtm_dmi_ctrl;

    localparam int ABITS = 7;

    logic               tclk;
    logic               trst;
    logic               upd_valid;
    logic [1:0]         upd_op;
    logic [ABITS-1:0]   upd_addr;
    logic [31:0]        upd_data;
    logic               capture;
    logic [ABITS+33:0]  cap_dmi;
    logic               dmireset;
    logic               dmihardreset;
    logic [1:0]         dmistat;
    logic               busy;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [ABITS-1:0]   req_addr;
    logic [31:0]        req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_op;
    logic [31:0]        rsp_data;

    int errors;
    int checks;

    // Reference model: what the transaction currently waits for, plus the
    // architectural DMI state.
    bit               m_outstanding;  // a transaction is in progress
    bit               m_granted;      // its request has been accepted
    logic [1:0]       m_op;
    logic [ABITS-1:0] m_addr;
    logic [31:0]      m_data;
    logic [ABITS-1:0] m_last;
    logic [31:0]      m_res;
    logic [1:0]       m_stat;

    dtm_dmi_ctrl #(.ABITS(ABITS)) dut (
        .tclk         (tclk),
        .trst         (trst),
        .upd_valid    (upd_valid),
        .upd_op       (upd_op),
        .upd_addr     (upd_addr),
        .upd_data     (upd_data),
        .capture      (capture),
        .cap_dmi      (cap_dmi),
        .dmireset     (dmireset),
        .dmihardreset (dmihardreset),
        .dmistat      (dmistat),
        .busy         (busy),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_op       (rsp_op),
        .rsp_data     (rsp_data)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_outstanding = 1'b0;
        m_granted     = 1'b0;
        m_op          = 2'd0;
        m_addr        = '0;
        m_data        = 32'd0;
        m_last        = '0;
        m_res         = 32'd0;
        m_stat        = 2'd0;
    endtask

    // Apply the DMI rules for one clock edge using the current inputs.
    task automatic model_step();
        bit         busy_err;
        bit         rsp_err;
        logic [1:0] base;
        busy_err = 1'b0;
        rsp_err  = 1'b0;
        if (dmihardreset) begin
            m_outstanding = 1'b0;
            m_granted     = 1'b0;
            m_stat        = 2'd0;
        end else begin
            busy_err = m_outstanding && (upd_valid || capture);
            if (!m_outstanding) begin
                if (upd_valid && m_stat == 2'd0 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
                    m_outstanding = 1'b1;
                    m_granted     = 1'b0;
                    m_op          = upd_op;
                    m_addr        = upd_addr;
                    m_data        = upd_data;
                    m_last        = upd_addr;
                end
            end else if (!m_granted) begin
                if (req_ready) m_granted = 1'b1;
            end else if (rsp_valid) begin
                m_outstanding = 1'b0;
                m_granted     = 1'b0;
                if (m_op == 2'd1) m_res = rsp_data;
                rsp_err = (rsp_op >= 2'd2);
            end
            base = dmireset ? 2'd0 : m_stat;
            if (base != 2'd0)  m_stat = base;
            else if (busy_err) m_stat = 2'd3;
            else if (rsp_err)  m_stat = rsp_op;
            else               m_stat = 2'd0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] cop;
        cop = m_outstanding ? 2'd3 : m_stat;
        check({tag, ".busy"},      busy,      m_outstanding);
        check({tag, ".req_valid"}, req_valid, m_outstanding && !m_granted);
        check({tag, ".rsp_ready"}, rsp_ready, m_outstanding && m_granted);
        check({tag, ".req_op"},    req_op,    m_op);
        check({tag, ".req_addr"},  req_addr,  m_addr);
        check({tag, ".req_data"},  req_data,  m_data);
        check({tag, ".dmistat"},   dmistat,   m_stat);
        check({tag, ".cap_dmi"},   cap_dmi,   {m_last, m_res, cop});
    endtask

    task automatic tick();
        model_step();
        @(posedge tclk);
        #1;
        check_all("cyc");
        upd_valid    = 1'b0;
        capture      = 1'b0;
        dmireset     = 1'b0;
        dmihardreset = 1'b0;
    endtask

    task automatic update(input logic [1:0] op, input logic [ABITS-1:0] a, input logic [31:0] d);
        upd_valid = 1'b1;
        upd_op    = op;
        upd_addr  = a;
        upd_data  = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        trst = 1'b0;
        upd_valid = 1'b0; upd_op = 2'd0; upd_addr = '0; upd_data = 32'd0;
        capture = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_op = 2'd0; rsp_data = 32'd0;
        model_reset();
        #3;
        check_all("reset");
        check("reset_outs", {busy, req_valid, rsp_ready, dmistat, cap_dmi}, 64'd0);
        @(negedge tclk);
        trst = 1'b1;

        // Write with immediate ready/response.
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_op = 2'd0; rsp_data = 32'hCAFE0000;
        update(2'd2, 7'h10, 32'hDEADBEEF);
        tick();
        check("wr_req", {req_valid, req_op, req_addr, req_data}, {1'b1, 2'd2, 7'h10, 32'hDEADBEEF});
        tick();
        check("wr_req_once", req_valid, 1'b0);
        tick();
        check("wr_busy_low", busy, 1'b0);
        check("wr_cap", {cap_dmi[40:34], cap_dmi[1:0]}, {7'h10, 2'd0});

        // Read.
        rsp_data = 32'h12345678;
        update(2'd1, 7'h11, 32'h0);
        tick(); tick(); tick();
        check("rd_cap", cap_dmi, {7'h11, 32'h12345678, 2'd0});

        // Update while busy.
        req_ready = 1'b0; rsp_valid = 1'b0;
        update(2'd2, 7'h30, 32'h00000030);
        tick();
        update(2'd2, 7'h20, 32'h00000020);
        tick();
        check("busy_stat", {dmistat, req_addr}, {2'd3, 7'h30});
        req_ready = 1'b1; rsp_valid = 1'b1;
        tick(); tick();
        update(2'd1, 7'h50, 32'h0);
        tick();
        check("sticky_ignore", busy, 1'b0);
        dmireset = 1'b1;
        tick();
        check("dmireset_clr", dmistat, 2'd0);
        update(2'd1, 7'h40, 32'h0);
        tick();
        check("rd_accept", {busy, req_op, req_addr}, {1'b1, 2'd1, 7'h40});
        tick(); tick();

        // Capture during WAIT_RSP, later failure does not overwrite.
        rsp_valid = 1'b0;
        update(2'd1, 7'h12, 32'h0);
        tick(); tick();
        capture = 1'b1;
        #1;
        check("cap_wait_op", cap_dmi[1:0], 2'd3);
        tick();
        check("cap_wait_stat", dmistat, 2'd3);
        rsp_valid = 1'b1; rsp_op = 2'd2;
        tick();
        check("first_err_wins", dmistat, 2'd3);
        dmireset = 1'b1;
        tick();

        // Failed write response, then dmireset colliding with busy capture.
        update(2'd2, 7'h13, 32'h13131313);
        tick(); tick(); tick();
        check("fail_stat", dmistat, 2'd2);
        dmireset = 1'b1;
        tick();
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_op = 2'd0;
        update(2'd2, 7'h14, 32'h14141414);
        tick();
        capture = 1'b1; dmireset = 1'b1;
        tick();
        check("reset_vs_set", dmistat, 2'd3);

        // Hard reset during REQ.
        dmihardreset = 1'b1;
        update(2'd1, 7'h15, 32'h0);
        tick();
        check("hard_rst", {busy, req_valid, rsp_ready, dmistat}, {1'b0, 1'b0, 1'b0, 2'd0});
        rsp_valid = 1'b1; rsp_op = 2'd2; rsp_data = 32'hBAD0BAD0;
        tick();
        check("hard_late_rsp", {dmistat, cap_dmi[33:2]}, {2'd0, 32'h12345678});
        rsp_valid = 1'b0;
        update(2'd0, 7'h77, 32'h0);
        tick();
        check("nop_upd", {busy, cap_dmi[40:34]}, {1'b0, 7'h14});

        // Async trst mid-transaction.
        update(2'd2, 7'h22, 32'h22222222);
        tick();
        #2;
        trst = 1'b0;
        #1;
        model_reset();
        check_all("trst");
        @(negedge tclk);
        trst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            upd_valid    = ($urandom_range(0, 3) == 0);
            upd_op       = 2'($urandom_range(0, 3));
            upd_addr     = 7'($urandom);
            upd_data     = $urandom;
            capture      = ($urandom_range(0, 5) == 0);
            dmireset     = ($urandom_range(0, 9) == 0);
            dmihardreset = ($urandom_range(0, 39) == 0);
            req_ready    = ($urandom_range(0, 1) == 1);
            rsp_valid    = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: rsp_op = 2'd2;
                1: rsp_op = 2'd3;
                default: rsp_op = 2'd0;
            endcase
            rsp_data     = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dtm_dmi_ctrl.md
Name: dtm_dmi_ctrl

Overview:
- Sequences RISC-V Debug Module Interface (DMI) transactions on behalf of the JTAG DTM.
- Sits in the tclk domain between the DTM's DMI data register and the Debug Module request/response bus.
- Accepts an op/addr/data word when the DTM updates the DMI register, then drives one valid/ready request and collects the response.
- Supplies the capture value for the next DMI scan and maintains the sticky dmistat error (dtmcs dmireset/dmihardreset semantics).

Parameters:
- ABITS, 7, DMI address width; the DTM scan word is ABITS+34 bits, laid out {addr, data[31:0], op[1:0]}.

Ports:
- tclk  in  1  JTAG clock; all logic on posedge.
- trst  in  1  async active-low reset.
- upd_valid  in  1  one-cycle pulse: DTM in UPDATE_DR with the DMI instruction.
- upd_op  in  2  0=nop, 1=read, 2=write, 3=reserved (treated as nop).
- upd_addr  in  ABITS  scanned address.
- upd_data  in  32  scanned write data.
- capture  in  1  one-cycle pulse: DTM in CAPTURE_DR with the DMI instruction.
- cap_dmi  out  ABITS+34  value the DTM loads on capture, laid out {last_addr, result_data, cap_op}; combinational from registers.
- dmireset  in  1  pulse; clears sticky dmistat.
- dmihardreset  in  1  pulse; aborts the transaction and clears dmistat.
- dmistat  out  2  sticky status: 0=ok, 2=failed, 3=busy.
- busy  out  1  high when state != IDLE.
- req_valid  out  1  request valid.
- req_ready  in  1  Debug Module accepts the request.
- req_op  out  2  1=read, 2=write.
- req_addr  out  ABITS  request address.
- req_data  out  32  request write data.
- rsp_valid  in  1  response valid.
- rsp_ready  out  1  controller accepts the response.
- rsp_op  in  2  0=ok, 2=failed, 3=busy.
- rsp_data  in  32  read data.

Behaviour:
- Reset: state=IDLE. req_valid, rsp_ready, busy, req_op, req_addr, req_data, dmistat, last_addr and result_data are all 0.
- FSM states:
  - IDLE: busy=0.
  - REQ: req_valid=1. req_op/req_addr/req_data are held stable from registers.
  - WAIT_RSP: rsp_ready=1, req_valid=0.
- IDLE -> REQ: on upd_valid with upd_op in {1,2} and dmistat==0.
  - Latch op, addr and data; last_addr is set to upd_addr.
  - req_valid rises in the cycle after the upd_valid edge.
- IDLE, other updates: upd_op 0 or 3 causes no transaction and leaves last_addr unchanged. With dmistat!=0, every upd_valid is ignored.
- REQ -> WAIT_RSP: at the edge where req_valid & req_ready. rsp_ready is high from the next cycle.
- WAIT_RSP -> IDLE: at the edge where rsp_valid & rsp_ready.
  - result_data <= rsp_data for reads.
  - result_data is unchanged for writes.
  - If rsp_op is 2 or 3 and dmistat==0, set dmistat <= rsp_op.
- rsp_valid outside WAIT_RSP is ignored (rsp_ready low).
- Update while busy (upd_valid with state != IDLE):
  - The update is dropped.
  - If dmistat==0, dmistat <= 3.
  - The outstanding transaction continues unaffected.
- Capture:
  - cap_op = 3 if state != IDLE, else dmistat.
  - Capture while state != IDLE also sets dmistat <= 3 if it was 0.
  - cap_dmi reflects register values before the capture edge.
- dmistat is sticky: it changes only on the 0 -> nonzero transitions above, or on dmireset/dmihardreset.
  - The first error wins; later errors do not overwrite it.
  - dmireset and a sticky-set event in the same cycle: the set wins, so no error is lost.
- dmihardreset has the highest priority.
  - Next cycle: state=IDLE, req_valid=0, rsp_ready=0, dmistat=0.
  - result_data and last_addr are kept.
  - An in-flight response is dropped; rsp_valid arriving afterwards is ignored.
  - An upd_valid in the same cycle is ignored.
- Async trst mid-transaction: all outputs return to their reset values immediately.
- Best-case latency, upd_valid to IDLE: 3 edges (REQ and WAIT_RSP one cycle each, ready and valid already high).

Test Plan:
- Write: upd_op=2, addr=0x10, data=0xDEADBEEF, req_ready=1, then rsp_valid with rsp_op=0 -> req_valid for exactly one cycle with 2/0x10/0xDEADBEEF; busy low 3 edges after the update; capture gives cap_op=0 and last_addr=0x10.
- Read: upd_op=1, addr=0x11; response 0x12345678 with rsp_op=0 -> capture yields {0x11, 0x12345678, 0}.
- Busy: update with req_ready held 0, then a second upd_valid (op=2, addr=0x20) -> second update dropped, dmistat=3, req_addr still first addr. Then:
  - next upd_valid ignored;
  - dmireset -> dmistat=0;
  - new read accepted.
- Capture while WAIT_RSP -> cap_op=3 and dmistat=3. A later rsp_op=2 leaves dmistat=3 (first error wins).
- Failed response: rsp_op=2 on a write -> dmistat=2. dmireset in the same cycle as a busy-causing capture -> dmistat=3.
- dmihardreset during REQ with req_ready=0 -> IDLE next cycle, req_valid=0, dmistat=0. A later rsp_valid is ignored, and a nop update leaves the state unchanged.
